nvram_upload_server: RTL and testbench
======================================

# nvram_upload_server

Serves core-side RAM contents to the HPS during an `ioctl` upload (save of NVRAM / high-score area), the reverse direction of the ROM download path into the core. Sits in `emu` between `hps_io` (`ioctl_upload`, `ioctl_rd`, `ioctl_addr`, `ioctl_din`, `ioctl_wait`) and a synchronous read port on the game's work RAM. While the upload runs, it pauses the game CPU so the served image is coherent.

## Interface
- `ADDR_W`, 16: core RAM address width.
- `BASE_ADDR`, 16'h8000: RAM address that maps to upload offset 0.
- `LEN`, 256: bytes served; offsets ≥ LEN read as 8'hFF.
- `RAM_LATENCY`, 1: cycles from `ram_rd` to valid `ram_q` (1..3).

Ports:
- `clk_sys`  in  1  system clock. Single clock domain; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ioctl_upload`  in  1  level, high for the whole upload.
- `ioctl_rd`  in  1  one-cycle byte-request pulse.
- `ioctl_addr`  in  25  byte offset, valid with `ioctl_rd`.
- `ioctl_din`  out  8  served byte.
- `ioctl_wait`  out  1  HPS must not sample or issue a new `ioctl_rd` while high.
- `pause_req`  out  1  request CPU halt.
- `pause_ack`  in  1  CPU halted (level).
- `ram_addr`  out  ADDR_W  RAM read address.
- `ram_rd`  out  1  one-cycle read strobe.
- `ram_q`  in  8  RAM read data.
- `bytes_served`  out  16  count of completed reads in the current upload.

## Operation
- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `pause_req`=0, `ram_addr`=0, `ram_rd`=0, `bytes_served`=0, state IDLE.
- IDLE: `ioctl_upload` high → PAUSE. At the same edge: `pause_req`=1, `ioctl_wait`=1, `bytes_served`=0.
- PAUSE: hold `ioctl_wait`=1 until `pause_ack` is sampled high → READY, `ioctl_wait`=0.
- READY: `ioctl_rd` sampled high → FETCH. At the same edge:
  - latch offset;
  - `ram_addr` = BASE_ADDR + offset[ADDR_W-1:0], modulo 2^ADDR_W (wrap);
  - `ram_rd`=1 for exactly one cycle;
  - `ioctl_wait`=1;
  - latency counter = RAM_LATENCY.
- Out-of-range offset (offset ≥ LEN, all 25 bits compared): no `ram_rd` pulse and `ram_addr` unchanged. The same wait duration still applies, then `ioctl_din`=8'hFF.
- FETCH: decrement the counter each cycle. On the edge after the counter reaches 0: `ioctl_din` ← `ram_q` (or FF), `ioctl_wait`=0, `bytes_served`+1 (saturates at FFFF), → READY.
- `ioctl_rd` in PAUSE or FETCH: ignored; no queuing.
- `ioctl_upload` falling in any state → IDLE at the next edge, with `pause_req`=0, `ioctl_wait`=0, `ram_rd`=0. An in-flight fetch is abandoned and `ioctl_din` keeps its last value. `bytes_served` holds until the next upload starts.
- `pause_ack` dropping in READY/FETCH: no effect. `pause_req` stays high for the whole upload.
- `reset` overrides everything in the same cycle, including mid-fetch.

## Timing
- Request `ioctl_rd` sampled at edge T (READY):
  - `ram_rd`=1 during cycle T..T+1;
  - `ioctl_wait` high from after T to after T+RAM_LATENCY+1;
  - `ioctl_din` valid after edge T+RAM_LATENCY+1 (3 rising edges for latency 1) and held until the next completed read.
- Upload start: `pause_req` and `ioctl_wait` rise one edge after `ioctl_upload` is first sampled high. `ioctl_wait` falls one edge after `pause_ack` is sampled high.
- Back-to-back: the earliest next accepted `ioctl_rd` is at the edge after `ioctl_wait` deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-FETCH (offset 3, latency 2) → next cycle all outputs at reset values, state IDLE.
- Upload start with `pause_ack` delayed 10 cycles → `pause_req`=1 and `ioctl_wait`=1 throughout, `ioctl_wait` falls 1 cycle after ack; an `ioctl_rd` pulsed during PAUSE produces no `ram_rd`.
- RAM preloaded with byte = offset^8'h5A; read offsets 0,1,255 with latency 1 → `ram_addr`=8000,8001,80FF; `ioctl_din`=5A,5B,A5 each 3 edges after the request; `bytes_served`=3.
- Offset 256 and offset 25'h1000000 → no `ram_rd`, `ioctl_din`=FF, same wait length.
- BASE_ADDR=FFF0, offset 20 (LEN=256) → `ram_addr`=0004 (wrap).
- `ioctl_upload` dropped 1 cycle after `ioctl_rd` (latency 3) → next edge `pause_req`=0, `ioctl_wait`=0, `ioctl_din` unchanged; a new upload resets `bytes_served` to 0.

Source files
------------

// File: rtl/nvram_upload_server.sv
// nvram_upload_server
// Serves core work-RAM bytes to the HPS during an ioctl upload (NVRAM /
// high-score save). The game CPU is held paused for the whole upload so the
// image is coherent. Offsets at or beyond LEN read back as 8'hFF without
// touching the RAM; every request costs the same number of cycles.
module nvram_upload_server #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h8000,
    parameter int                LEN         = 256,
    parameter int                RAM_LATENCY = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic [15:0]       bytes_served
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAUSE,
        S_READY,
        S_FETCH
    } state_t;

    // Latency counter is two bits wide; RAM_LATENCY is limited to 1..3.
    localparam logic [1:0]  LAT     = 2'(RAM_LATENCY);
    localparam logic [24:0] LEN_LIM = 25'(LEN);

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              oor_reg, oor_next;
    logic [7:0]        din_reg, din_next;
    logic              wait_reg, wait_next;
    logic              pause_reg, pause_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rd_reg, rd_next;
    logic [15:0]       served_reg, served_next;

    // Full 25-bit compare so huge offsets never alias into the RAM window.
    logic in_range;
    assign in_range = (ioctl_addr < LEN_LIM);

    // State and registered outputs; reset wins over everything, mid-fetch too.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            oor_reg    <= 1'b0;
            din_reg    <= '0;
            wait_reg   <= 1'b0;
            pause_reg  <= 1'b0;
            addr_reg   <= '0;
            rd_reg     <= 1'b0;
            served_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            oor_reg    <= oor_next;
            din_reg    <= din_next;
            wait_reg   <= wait_next;
            pause_reg  <= pause_next;
            addr_reg   <= addr_next;
            rd_reg     <= rd_next;
            served_reg <= served_next;
        end
    end

    // Next-state logic; losing ioctl_upload returns to IDLE from anywhere.
    always_comb begin
        state_next = state_reg;
        if (!ioctl_upload) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  state_next = S_PAUSE;
                S_PAUSE: if (pause_ack) state_next = S_READY;
                S_READY: if (ioctl_rd) state_next = S_FETCH;
                S_FETCH: if (cnt_reg == 2'd0) state_next = S_READY;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values, registered above.
    always_comb begin
        cnt_next    = cnt_reg;
        oor_next    = oor_reg;
        din_next    = din_reg;
        wait_next   = wait_reg;
        pause_next  = pause_reg;
        addr_next   = addr_reg;
        rd_next     = 1'b0;
        served_next = served_reg;
        if (!ioctl_upload) begin
            // Abandon any fetch; served byte and count are left as they were.
            pause_next = 1'b0;
            wait_next  = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    pause_next  = 1'b1;
                    wait_next   = 1'b1;
                    served_next = '0;
                end
                S_PAUSE: begin
                    if (pause_ack) wait_next = 1'b0;
                end
                S_READY: begin
                    if (ioctl_rd) begin
                        wait_next = 1'b1;
                        cnt_next  = LAT;
                        oor_next  = !in_range;
                        if (in_range) begin
                            addr_next = BASE_ADDR + ioctl_addr[ADDR_W-1:0];
                            rd_next   = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (cnt_reg != 2'd0) begin
                        cnt_next = cnt_reg - 2'd1;
                    end else begin
                        din_next  = oor_reg ? 8'hFF : ram_q;
                        wait_next = 1'b0;
                        if (served_reg != 16'hFFFF) served_next = served_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ioctl_din    = din_reg;
    assign ioctl_wait   = wait_reg;
    assign pause_req    = pause_reg;
    assign ram_addr     = addr_reg;
    assign ram_rd       = rd_reg;
    assign bytes_served = served_reg;

endmodule

// File: tb/tb_nvram_upload_server.sv
// Bench for nvram_upload_server. Three instances share one stimulus stream:
// k=0 base 8000/latency 1, k=1 base 8000/latency 2, k=2 base FFF0/latency 3.
// Each RAM holds byte = offset ^ 8'h5A relative to its instance's base.
module tb_nvram_upload_server;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic        pause_ack = 1'b0;

    logic [7:0]  din_w      [3];
    logic        wait_w     [3];
    logic        pause_w    [3];
    logic [15:0] ram_addr_w [3];
    logic        ram_rd_w   [3];
    logic [7:0]  ram_q_w    [3];
    logic [15:0] bytes_w    [3];
    logic [7:0]  pipe_d     [3][3];

    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] base_of(input int k);
        return (k == 2) ? 16'hFFF0 : 16'h8000;
    endfunction

    function automatic int lat_of(input int k);
        return k + 1;
    endfunction

    function automatic logic [7:0] ram_image(input int k, input logic [15:0] a);
        logic [15:0] off;
        off = a - base_of(k);
        return off[7:0] ^ 8'h5A;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            nvram_upload_server #(
                .ADDR_W      (16),
                .BASE_ADDR   ((gi == 2) ? 16'hFFF0 : 16'h8000),
                .LEN         (256),
                .RAM_LATENCY (gi + 1)
            ) u_dut (
                .clk_sys      (clk_sys),
                .reset        (reset),
                .ioctl_upload (ioctl_upload),
                .ioctl_rd     (ioctl_rd),
                .ioctl_addr   (ioctl_addr),
                .ioctl_din    (din_w[gi]),
                .ioctl_wait   (wait_w[gi]),
                .pause_req    (pause_w[gi]),
                .pause_ack    (pause_ack),
                .ram_addr     (ram_addr_w[gi]),
                .ram_rd       (ram_rd_w[gi]),
                .ram_q        (ram_q_w[gi]),
                .bytes_served (bytes_w[gi])
            );
            assign ram_q_w[gi] = pipe_d[gi][gi];
        end
    endgenerate

    // Synchronous RAM models; data only appears for a strobed read, else EE.
    always @(posedge clk_sys) begin
        for (int k = 0; k < 3; k++) begin
            pipe_d[k][2] <= pipe_d[k][1];
            pipe_d[k][1] <= pipe_d[k][0];
            pipe_d[k][0] <= ram_rd_w[k] ? ram_image(k, ram_addr_w[k]) : 8'hEE;
        end
    end

    // Reference model: tracks upload/grant/busy and the cycle a read completes.
    int          cyc = 0;
    logic        m_up    [3];
    logic        m_grant [3];
    logic        m_busy  [3];
    int          m_done  [3];
    logic [7:0]  m_pend  [3];
    logic [7:0]  e_din   [3];
    logic        e_wait  [3];
    logic        e_pause [3];
    logic        e_rd    [3];
    logic [15:0] e_addr  [3];
    logic [15:0] e_bytes [3];

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e_rd[k] <= 1'b0;
            if (reset) begin
                m_up[k] <= 1'b0; m_grant[k] <= 1'b0; m_busy[k] <= 1'b0;
                e_din[k] <= 8'h00; e_wait[k] <= 1'b0; e_pause[k] <= 1'b0;
                e_addr[k] <= 16'h0000; e_bytes[k] <= 16'h0000;
            end else if (!m_up[k]) begin
                if (ioctl_upload) begin
                    m_up[k] <= 1'b1; m_grant[k] <= 1'b0; m_busy[k] <= 1'b0;
                    e_pause[k] <= 1'b1; e_wait[k] <= 1'b1; e_bytes[k] <= 16'h0000;
                end
            end else if (!ioctl_upload) begin
                m_up[k] <= 1'b0; m_busy[k] <= 1'b0;
                e_pause[k] <= 1'b0; e_wait[k] <= 1'b0;
            end else if (!m_grant[k]) begin
                if (pause_ack) begin
                    m_grant[k] <= 1'b1;
                    e_wait[k] <= 1'b0;
                end
            end else if (m_busy[k]) begin
                if (cyc == m_done[k]) begin
                    m_busy[k] <= 1'b0;
                    e_din[k] <= m_pend[k];
                    e_wait[k] <= 1'b0;
                    if (e_bytes[k] != 16'hFFFF) e_bytes[k] <= e_bytes[k] + 16'd1;
                end
            end else if (ioctl_rd) begin
                m_busy[k] <= 1'b1;
                m_done[k] <= cyc + lat_of(k) + 1;
                e_wait[k] <= 1'b1;
                if (ioctl_addr < 25'd256) begin
                    e_addr[k] <= base_of(k) + ioctl_addr[15:0];
                    e_rd[k]   <= 1'b1;
                    m_pend[k] <= ioctl_addr[7:0] ^ 8'h5A;
                end else begin
                    m_pend[k] <= 8'hFF;
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check("din", k, 32'(din_w[k]), 32'(e_din[k]));
            check("wait", k, 32'(wait_w[k]), 32'(e_wait[k]));
            check("pause_req", k, 32'(pause_w[k]), 32'(e_pause[k]));
            check("ram_addr", k, 32'(ram_addr_w[k]), 32'(e_addr[k]));
            check("ram_rd", k, 32'(ram_rd_w[k]), 32'(e_rd[k]));
            check("bytes_served", k, 32'(bytes_w[k]), 32'(e_bytes[k]));
        end
    endtask

    // Advance one clock, then compare every instance against the model.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        compare_all();
    endtask

    int          r_edges [3];
    int          r_rdcnt [3];
    logic [15:0] r_addr  [3];

    // One request; records ram_addr after the accepting edge, strobe count,
    // and the edge (counted from the accepting edge) where wait dropped.
    task automatic do_read(input logic [24:0] a);
        int  n;
        bit  all_done;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        tick();
        ioctl_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r_rdcnt[k] = int'(ram_rd_w[k]);
            r_addr[k]  = ram_addr_w[k];
            r_edges[k] = 0;
        end
        n = 0;
        all_done = 1'b0;
        while (!all_done && n < 20) begin
            tick();
            n++;
            all_done = 1'b1;
            for (int k = 0; k < 3; k++) begin
                r_rdcnt[k] += int'(ram_rd_w[k]);
                if (r_edges[k] == 0 && !wait_w[k]) r_edges[k] = n;
                if (r_edges[k] == 0) all_done = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            check("wait_edges", k, 32'(r_edges[k]), 32'(lat_of(k) + 1));
            check("rd_pulses", k, 32'(r_rdcnt[k]), (a < 25'd256) ? 32'd1 : 32'd0);
        end
        $display("read offset=%h din=%h/%h/%h ram_addr=%h/%h/%h edges=%0d/%0d/%0d",
                 a, din_w[0], din_w[1], din_w[2], r_addr[0], r_addr[1], r_addr[2],
                 r_edges[0], r_edges[1], r_edges[2]);
    endtask

    initial begin
        int rd_seen;
        int hold_bad;

        // Reset values
        tick(); tick(); tick();
        check("rst_din", 0, 32'(din_w[0]), 32'h00);
        check("rst_wait", 0, 32'(wait_w[0]), 32'h0);
        check("rst_pause", 0, 32'(pause_w[0]), 32'h0);
        check("rst_ram_addr", 0, 32'(ram_addr_w[0]), 32'h0000);
        check("rst_bytes", 0, 32'(bytes_w[0]), 32'h0000);
        reset = 1'b0;
        tick();

        // Upload start, ack delayed 10 cycles, stray ioctl_rd during PAUSE
        ioctl_upload = 1'b1;
        tick();
        check("start_pause", 0, 32'(pause_w[0]), 32'h1);
        check("start_wait", 0, 32'(wait_w[0]), 32'h1);
        rd_seen  = 0;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            ioctl_rd = (i == 4);
            tick();
            for (int k = 0; k < 3; k++) begin
                rd_seen += int'(ram_rd_w[k]);
                if (!pause_w[k] || !wait_w[k]) hold_bad++;
            end
        end
        ioctl_rd = 1'b0;
        check("pause_rd_pulses", 0, 32'(rd_seen), 32'd0);
        check("pause_hold", 0, 32'(hold_bad), 32'd0);
        pause_ack = 1'b1;
        tick();
        check("ack_wait_fall", 0, 32'(wait_w[0]), 32'h0);
        check("ack_wait_fall", 2, 32'(wait_w[2]), 32'h0);

        // In-range reads
        do_read(25'd0);
        check("lit_addr0", 0, 32'(r_addr[0]), 32'h8000);
        check("lit_din0", 0, 32'(din_w[0]), 32'h5A);
        do_read(25'd1);
        check("lit_addr1", 0, 32'(r_addr[0]), 32'h8001);
        check("lit_din1", 0, 32'(din_w[0]), 32'h5B);
        do_read(25'd255);
        check("lit_addr255", 0, 32'(r_addr[0]), 32'h80FF);
        check("lit_addr255", 2, 32'(r_addr[2]), 32'h00EF);
        check("lit_din255", 0, 32'(din_w[0]), 32'hA5);
        check("lit_din255", 2, 32'(din_w[2]), 32'hA5);
        check("lit_bytes3", 0, 32'(bytes_w[0]), 32'd3);

        // Out-of-range reads
        do_read(25'd256);
        check("lit_oor_din", 1, 32'(din_w[1]), 32'hFF);
        check("lit_oor_addr", 0, 32'(r_addr[0]), 32'h80FF);
        do_read(25'h1000000);
        check("lit_big_din", 0, 32'(din_w[0]), 32'hFF);

        // Address wrap on the FFF0-based instance
        do_read(25'd20);
        check("lit_wrap_addr", 2, 32'(r_addr[2]), 32'h0004);
        check("lit_addr20", 0, 32'(r_addr[0]), 32'h8014);
        check("lit_din20", 2, 32'(din_w[2]), 32'h4E);
        check("lit_bytes6", 1, 32'(bytes_w[1]), 32'd6);

        // pause_ack dropping while READY has no effect
        pause_ack = 1'b0;
        do_read(25'd5);
        check("lit_din5", 0, 32'(din_w[0]), 32'h5F);
        check("lit_bytes7", 2, 32'(bytes_w[2]), 32'd7);

        // Upload dropped one cycle after a request
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd7;
        tick();
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        tick();
        check("drop_pause", 2, 32'(pause_w[2]), 32'h0);
        check("drop_wait", 2, 32'(wait_w[2]), 32'h0);
        check("drop_din", 2, 32'(din_w[2]), 32'h5F);
        check("drop_din", 0, 32'(din_w[0]), 32'h5F);
        check("drop_bytes", 2, 32'(bytes_w[2]), 32'd7);
        $display("upload dropped: pause=%b wait=%b din=%h", pause_w[2], wait_w[2], din_w[2]);
        tick();

        // New upload clears the count
        ioctl_upload = 1'b1;
        tick();
        check("restart_bytes", 0, 32'(bytes_w[0]), 32'd0);
        check("restart_pause", 1, 32'(pause_w[1]), 32'h1);
        pause_ack = 1'b1;
        tick();

        // Reset during a fetch (offset 3)
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd3;
        tick();
        ioctl_rd     = 1'b0;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        tick();
        check("midrst_din", 1, 32'(din_w[1]), 32'h00);
        check("midrst_wait", 1, 32'(wait_w[1]), 32'h0);
        check("midrst_pause", 1, 32'(pause_w[1]), 32'h0);
        check("midrst_ram_addr", 1, 32'(ram_addr_w[1]), 32'h0000);
        check("midrst_ram_rd", 1, 32'(ram_rd_w[1]), 32'h0);
        check("midrst_bytes", 1, 32'(bytes_w[1]), 32'h0000);
        $display("reset mid-fetch: din=%h wait=%b ram_addr=%h", din_w[1], wait_w[1], ram_addr_w[1]);
        reset     = 1'b0;
        pause_ack = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
